button_repeat_gen: RTL and testbench

Front-end conditioner that turns raw on-board up/down push-buttons into clean, single-cycle step pulses for the button-driven counters and LED displays on the SoC. Each raw input is synchronised, debounced, arbitrated against the other button, and converted to a press pulse, followed by optional auto-repeat pulses while held. It drives the up/down inputs of a counter in the fast `clk` domain, so no slow divided clock is needed downstream.

---
 rtl/button_repeat_gen.sv | 219 +++++++++++++++++++++
 tb/tb_button_repeat_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_repeat_gen.sv
// button_repeat_gen: turns raw bouncy up/down push-buttons into clean one-cycle
// step pulses in the clk domain. Each input is synchronised, debounced and
// arbitrated. An accepted press fires one pulse immediately.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN. When it is
// defined, a held button first repeats after HOLD_CYCLES and then every
// REPEAT_CYCLES. When it is undefined, each accepted press gives exactly one pulse.
// Pressing both buttons locks out all pulses until both are released.

module button_repeat_gen #(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned REPEAT_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic up_pulse,
    output logic down_pulse,
    output logic up_db,
    output logic down_db
);

    // Reject cycle counts that the 16-bit counters cannot represent.
    if (DEB_CYCLES < 2 || DEB_CYCLES > 65535 ||
        HOLD_CYCLES < 2 || HOLD_CYCLES > 65535 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_params
        $error("button_repeat_gen: cycle parameters must lie in 2..65535");
    end

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 32'd1);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 32'd1);
    localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_LOCK = 2'd3
    } state_t;
`endif

    logic        up_s1_r, up_s2_r, down_s1_r, down_s2_r;
    logic [15:0] up_cnt_r, down_cnt_r;
    logic        up_db_r, down_db_r;
    logic        up_pulse_r, down_pulse_r;
    logic        up_pulse_s, down_pulse_s;
    state_t      state_r, state_s;
    logic        dir_r, dir_s;       // 1 = up, 0 = down
    logic        dir_db_s;           // debounced level of the latched direction
`ifdef BTN_AUTOREPEAT_EN
    logic [15:0] timer_r, timer_s;
`endif

    assign up_pulse   = up_pulse_r;
    assign down_pulse = down_pulse_r;
    assign up_db      = up_db_r;
    assign down_db    = down_db_r;

    assign dir_db_s = dir_r ? up_db_r : down_db_r;

    // Two-flop synchronisers bring the raw buttons into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_s1_r   <= 1'b0;
            up_s2_r   <= 1'b0;
            down_s1_r <= 1'b0;
            down_s2_r <= 1'b0;
        end else begin
            up_s1_r   <= btn_up;
            up_s2_r   <= up_s1_r;
            down_s1_r <= btn_down;
            down_s2_r <= down_s1_r;
        end
    end

    // Up debouncer: accept a new level only after DEB_CYCLES stable cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_cnt_r <= 16'd0;
            up_db_r  <= 1'b0;
        end else if (up_s2_r != up_db_r) begin
            if (up_cnt_r == DEB_LAST) begin
                up_db_r  <= up_s2_r;
                up_cnt_r <= 16'd0;
            end else begin
                up_cnt_r <= up_cnt_r + 16'd1;
            end
        end else begin
            up_cnt_r <= 16'd0;
        end
    end

    // Down debouncer: same filtering as the up input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            down_cnt_r <= 16'd0;
            down_db_r  <= 1'b0;
        end else if (down_s2_r != down_db_r) begin
            if (down_cnt_r == DEB_LAST) begin
                down_db_r  <= down_s2_r;
                down_cnt_r <= 16'd0;
            end else begin
                down_cnt_r <= down_cnt_r + 16'd1;
            end
        end else begin
            down_cnt_r <= 16'd0;
        end
    end

    // Arbitration FSM next state: both-pressed lock wins over release, and release wins over a due repeat.
    always_comb begin
        state_s      = state_r;
        dir_s        = dir_r;
        up_pulse_s   = 1'b0;
        down_pulse_s = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        timer_s      = timer_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (up_db_r && down_db_r) begin
                    state_s = ST_LOCK;
                end else if (up_db_r) begin
                    up_pulse_s = 1'b1;
                    dir_s      = 1'b1;
                    state_s    = ST_HOLD;
`ifdef BTN_AUTOREPEAT_EN
                    timer_s    = 16'd0;
`endif
                end else if (down_db_r) begin
                    down_pulse_s = 1'b1;
                    dir_s        = 1'b0;
                    state_s      = ST_HOLD;
`ifdef BTN_AUTOREPEAT_EN
                    timer_s      = 16'd0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (up_db_r && down_db_r) begin
                    state_s = ST_LOCK;
                end else if (!dir_db_s) begin
                    state_s = ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                end else if (timer_r == HOLD_LAST) begin
                    up_pulse_s   = dir_r;
                    down_pulse_s = ~dir_r;
                    timer_s      = 16'd0;
                    state_s      = ST_REPEAT;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
`else
                end else begin
                    state_s = ST_HOLD;
                end
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
            ST_REPEAT: begin
                if (up_db_r && down_db_r) begin
                    state_s = ST_LOCK;
                end else if (!dir_db_s) begin
                    state_s = ST_IDLE;
                end else if (timer_r == REPEAT_LAST) begin
                    up_pulse_s   = dir_r;
                    down_pulse_s = ~dir_r;
                    timer_s      = 16'd0;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
`endif
            ST_LOCK: begin
                if (!up_db_r && !down_db_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOCK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, direction, timer and registered pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            dir_r        <= 1'b0;
            up_pulse_r   <= 1'b0;
            down_pulse_r <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            timer_r      <= 16'd0;
`endif
        end else begin
            state_r      <= state_s;
            dir_r        <= dir_s;
            up_pulse_r   <= up_pulse_s;
            down_pulse_r <= down_pulse_s;
`ifdef BTN_AUTOREPEAT_EN
            timer_r      <= timer_s;
`endif
        end
    end

endmodule

// File: tb/tb_button_repeat_gen.sv
// Self-checking bench for button_repeat_gen. Expected pulses, each with the
// cycle at which it should appear and its direction, are derived from the
// press/release timing and pushed to a queue when the stimulus is driven. A
// monitor on the falling edge pops the queue and compares both pulse outputs
// on every cycle outside reset.

module tb_button_repeat_gen;

    localparam int unsigned DEB  = 16;
    localparam int unsigned HOLD = 64;
    localparam int unsigned REP  = 32;

    logic clk = 1'b0;
    logic reset;
    logic btn_up;
    logic btn_down;
    logic up_pulse;
    logic down_pulse;
    logic up_db;
    logic down_db;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int unsigned cyc;
        logic        up;
    } exp_t;
    exp_t exp_q[$];

    logic mon_up;
    logic mon_dn;

    button_repeat_gen #(
        .DEB_CYCLES(DEB),
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .up_pulse(up_pulse),
        .down_pulse(down_pulse),
        .up_db(up_db),
        .down_db(down_db)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Queue the pulses of a press driven when cyc == c, keeping only those due by cycle lim.
    task automatic push_press(input logic up, input int unsigned c, input int unsigned lim);
        int unsigned p;
        exp_t e;
        e.up = up;
        p = c + DEB + 3;
        if (p <= lim) begin
            e.cyc = p;
            exp_q.push_back(e);
        end
`ifdef BTN_AUTOREPEAT_EN
        p = p + HOLD;
        while (p <= lim) begin
            e.cyc = p;
            exp_q.push_back(e);
            p = p + REP;
        end
`endif
    endtask

    // Clean press held for 'hold' cycles, then released, then a settle gap.
    task automatic press(input logic up, input int unsigned hold);
        int unsigned c;
        c = cyc;
        if (up) btn_up = 1'b1;
        else    btn_down = 1'b1;
        // The debounced level falls DEB+2 edges after release, so pulses are possible up to c+hold+DEB+2.
        push_press(up, c, c + hold + DEB + 2);
        repeat (hold) @(negedge clk);
        if (up) btn_up = 1'b0;
        else    btn_down = 1'b0;
        repeat (DEB + 10) @(negedge clk);
    endtask

    // Scoreboard monitor: compare both pulse outputs against the queue head every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            mon_up = 1'b0;
            mon_dn = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                mon_up = exp_q[0].up;
                mon_dn = ~exp_q[0].up;
                void'(exp_q.pop_front());
            end
            check_eq("up_pulse", 32'(up_pulse), 32'(mon_up));
            check_eq("down_pulse", 32'(down_pulse), 32'(mon_dn));
        end
    end

    initial begin
        int unsigned c;
        int unsigned d;
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_up_pulse", 32'(up_pulse), 32'd0);
        check_eq("rst_down_pulse", 32'(down_pulse), 32'd0);
        check_eq("rst_up_db", 32'(up_db), 32'd0);
        check_eq("rst_down_db", 32'(down_db), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Clean up press: up_db rises on edge c+18, single pulse at c+19.
        c = cyc;
        btn_up = 1'b1;
        push_press(1'b1, c, c + 30 + DEB + 2);
        repeat (17) @(negedge clk);
        check_eq("up_db_before", 32'(up_db), 32'd0);
        @(negedge clk);
        check_eq("up_db_after", 32'(up_db), 32'd1);
        check_eq("down_db_idle", 32'(down_db), 32'd0);
        repeat (12) @(negedge clk);
        btn_up = 1'b0;
        repeat (DEB + 10) @(negedge clk);

        // Long down hold: first pulse, then repeats after HOLD and every REP.
        press(1'b0, 200);

        // Bounces shorter than the debounce window change nothing.
        btn_up = 1'b1;
        repeat (5) @(negedge clk);
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        btn_up = 1'b1;
        repeat (7) @(negedge clk);
        btn_up = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_eq("bounce_up_db", 32'(up_db), 32'd0);
        end
        press(1'b1, 30);

        // Lock: one up pulse, then no pulses through the overlap and the single release.
        c = cyc;
        btn_up = 1'b1;
        push_press(1'b1, c, c + 48);
        repeat (30) @(negedge clk);
        btn_down = 1'b1;
        repeat (30) @(negedge clk);
        btn_up = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("lock_down_db", 32'(down_db), 32'd1);
        check_eq("lock_up_db", 32'(up_db), 32'd0);
        btn_down = 1'b0;
        repeat (DEB + 10) @(negedge clk);
        // Back in IDLE: a fresh down press fires normally.
        press(1'b0, 25);

        // Reset during auto-repeat while up is held; held button is a new press afterwards.
        c = cyc;
        btn_up = 1'b1;
        push_press(1'b1, c, c + 99);
        repeat (100) @(negedge clk);
        check_eq("pre_reset_up_db", 32'(up_db), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("async_rst_up_db", 32'(up_db), 32'd0);
        check_eq("async_rst_up_pulse", 32'(up_pulse), 32'd0);
        check_eq("async_rst_down_pulse", 32'(down_pulse), 32'd0);
        check_eq("async_rst_down_db", 32'(down_db), 32'd0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        d = cyc;
        push_press(1'b1, d, d + 40 + DEB + 2);
        repeat (40) @(negedge clk);
        btn_up = 1'b0;
        repeat (DEB + 10) @(negedge clk);

        // Very long hold: one pulse without auto-repeat, a full repeat train with it.
        press(1'b1, 300);

        repeat (20) @(negedge clk);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
